// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receiver: register address map,
// frame geometry and the receiver state encoding.
// No ports; imported by max7219_rx.
package max7219_pkg;

  localparam int FRAME_BITS = 16;
  localparam int COUNT_W    = 5;

  // Bit counter constants kept at counter width so comparisons stay width-exact.
  localparam logic [COUNT_W-1:0] COUNT_MAX      = 5'd31;
  localparam logic [COUNT_W-1:0] COUNT_ONE      = 5'd1;
  localparam logic [COUNT_W-1:0] COUNT_FRAME    = 5'(FRAME_BITS);

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_LATCH     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/max7219_rx_sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous input, with
// single-cycle rise/fall strobes derived from the synchronized value.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   async_in      asynchronous input pin
//   sync_out      synchronized copy (STAGES cycles of latency)
//   rise, fall    one-cycle strobes on sync_out transitions (combinational
//                 from registers, so a consumer registering them sees the
//                 pin transition STAGES+1 cycles later)
module sync_edge #(
  parameter int   STAGES    = 2,     // minimum 2
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic chain_reg [STAGES];
  logic prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset) chain_reg[gi] <= RESET_VAL;
          else       chain_reg[gi] <= async_in;
        end
      end else begin : g_next
        always_ff @(posedge clock) begin
          if (reset) chain_reg[gi] <= RESET_VAL;
          else       chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) prev_reg <= RESET_VAL;
    else       prev_reg <= chain_reg[STAGES-1];
  end

  assign sync_out = chain_reg[STAGES-1];
  assign rise     = sync_out & ~prev_reg;
  assign fall     = ~sync_out & prev_reg;

endmodule

// File: rtl/max7219_rx.sv
// max7219_rx: oversampling receiver for the MAX7219 three-wire interface.
// Decodes latched 16-bit frames and keeps a shadow of the display register
// file for loopback / verification of the display driver.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   max_sck/max_cs/max_din asynchronous serial pins (CS active low)
//   max_dout              MSB of the shift register (daisy-chain output)
//   rd_addr / rd_data     digit read-back, one cycle registered latency
//   decode_mode, intensity, scan_limit, shutdown, display_test
//                         shadow control registers
//   frame_valid / frame_error  one-cycle pulses per good / short frame
//   last_addr / last_data address and data of the last good frame
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       max_sck,
  input  logic       max_cs,
  input  logic       max_din,
  output logic       max_dout,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       display_test,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [3:0] last_addr,
  output logic [7:0] last_data
);

  // ---------------------------------------------------------------- inputs
  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic din_sync, din_rise, din_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (max_sck),
    .sync_out (sck_sync),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (max_cs),
    .sync_out (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (max_din),
    .sync_out (din_sync),
    .rise     (din_rise),
    .fall     (din_fall)
  );

  // Only the SCK rising edge, CS level/edges and the DIN level matter.
  logic unused_sync;
  assign unused_sync = &{1'b0, sck_sync, sck_fall, din_rise, din_fall};

  // ------------------------------------------------------------------- FSM
  rx_state_t            state_reg, state_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic [15:0]          shreg_reg, shreg_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_WAIT_HIGH;
      count_reg <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shreg_reg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shreg_next = shreg_reg;
    case (state_reg)
      // After reset, wait for CS to be seen high so a frame that was in
      // flight when reset hit is dropped rather than half-decoded.
      ST_WAIT_HIGH: begin
        if (cs_sync) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SHIFT;
          count_next = '0;
        end
      end
      ST_SHIFT: begin
        // CS rise wins: an SCK edge in the same cycle is dropped.
        if (cs_rise) begin
          state_next = ST_LATCH;
        end else if (sck_rise) begin
          shreg_next = {shreg_reg[14:0], din_sync};
          if (count_reg != COUNT_MAX) count_next = count_reg + COUNT_ONE;
        end
      end
      ST_LATCH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_WAIT_HIGH;
      end
    endcase
  end

  // ---------------------------------------------------------------- decode
  logic       latch_active, frame_long, frame_ok, frame_short;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;

  assign latch_active = (state_reg == ST_LATCH);
  assign frame_long   = (count_reg >= COUNT_FRAME);
  assign frame_ok     = latch_active && frame_long;
  assign frame_short  = latch_active && !frame_long;
  // Longer frames simply leave their newest 16 bits in the shift register.
  assign frame_addr   = shreg_reg[11:8];
  assign frame_data   = shreg_reg[7:0];

  // --------------------------------------------------------- register file
  logic [7:0] digit_reg [8];
  logic [7:0] rd_data_reg;
  logic [7:0] decode_reg;
  logic [3:0] intensity_reg;
  logic [2:0] scan_reg;
  logic       shutdown_reg;
  logic       test_reg;
  logic       valid_reg, error_reg;
  logic [3:0] last_addr_reg;
  logic [7:0] last_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      localparam logic [3:0] DIGIT_ADDR = 4'(gi + 1);
      always_ff @(posedge clock) begin
        if (reset)
          digit_reg[gi] <= '0;
        else if (frame_ok && frame_addr == DIGIT_ADDR)
          digit_reg[gi] <= frame_data;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) rd_data_reg <= '0;
    else       rd_data_reg <= digit_reg[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      decode_reg    <= '0;
      intensity_reg <= '0;
      scan_reg      <= '0;
      shutdown_reg  <= 1'b1;
      test_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
      last_addr_reg <= '0;
      last_data_reg <= '0;
    end else begin
      valid_reg <= frame_ok;
      error_reg <= frame_short;
      if (frame_ok) begin
        last_addr_reg <= frame_addr;
        last_data_reg <= frame_data;
        case (frame_addr)
          ADDR_DECODE:    decode_reg    <= frame_data;
          ADDR_INTENSITY: intensity_reg <= frame_data[3:0];
          ADDR_SCANLIM:   scan_reg      <= frame_data[2:0];
          // Register holds "normal operation" in bit 0; the output is the
          // inverted sense so that reset reads as shut down.
          ADDR_SHUTDOWN:  shutdown_reg  <= ~frame_data[0];
          ADDR_TEST:      test_reg      <= frame_data[0];
          default: ;      // no-op, digits (handled above), 0xD, 0xE
        endcase
      end
    end
  end

  // --------------------------------------------------------------- outputs
  assign max_dout     = shreg_reg[15];
  assign rd_data      = rd_data_reg;
  assign decode_mode  = decode_reg;
  assign intensity    = intensity_reg;
  assign scan_limit   = scan_reg;
  assign shutdown     = shutdown_reg;
  assign display_test = test_reg;
  assign frame_valid  = valid_reg;
  assign frame_error  = error_reg;
  assign last_addr    = last_addr_reg;
  assign last_data    = last_data_reg;

endmodule

// File: doc/max7219_rx.md
# max7219_rx

Cycle-accurate receiver model of the MAX7219 serial display interface. It oversamples the three-wire stream (`max_sck`, `max_cs`, `max_din`) that the calculator FSM produces, decodes each latched 16-bit frame, and maintains a shadow copy of the display controller's register file. It is used as the verification and loopback counterpart of the display driver, in simulation and on the FPGA through a spare pin bank. It runs on the undivided system clock, so it oversamples the divided-clock SPI traffic.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- `clock`  in  1  system clock; every input is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `max_sck`  in  1  serial clock, asynchronous to `clock`.
- `max_cs`  in  1  chip select, active low, asynchronous to `clock`.
- `max_din`  in  1  serial data, MSB first, asynchronous to `clock`.
- `max_dout`  out  1  MSB of the shift register (daisy-chain output).
- `rd_addr`  in  3  digit index to read back.
- `rd_data`  out  8  digit register `rd_addr`, registered.
- `decode_mode`  out  8  register 0x9.
- `intensity`  out  4  register 0xA, bits [3:0].
- `scan_limit`  out  3  register 0xB, bits [2:0].
- `shutdown`  out  1  1 = display shut down; equals NOT data[0] of the last write to 0xC.
- `display_test`  out  1  register 0xF, bit 0.
- `frame_valid`  out  1  one-cycle pulse when a frame is latched.
- `frame_error`  out  1  one-cycle pulse when a frame is too short.
- `last_addr`  out  4  address of the last latched frame.
- `last_data`  out  8  data of the last latched frame.

## Operation
- Each of SCK, CS and DIN passes through a `SYNC_STAGES` synchronizer. SCK and CS also get rise/fall edge detection on the synchronized value.
- State machine:
  - WAIT_HIGH: entered from reset; moves to IDLE when synchronized CS = 1. This guarantees a reset that lands mid-frame is never resumed.
  - IDLE: a falling edge on CS moves to SHIFT; on entry the bit count is cleared.
  - SHIFT: on each SCK rising edge, shift the synchronized DIN into `shreg[15:0]` at the LSB and increment the bit count, saturating at 31. A CS rising edge moves to LATCH.
  - LATCH: lasts one cycle, then returns to IDLE.
- Decode, performed in LATCH:
  - If bit count < 16: pulse `frame_error`, change no register, and leave `last_*` unchanged.
  - Otherwise: address = `shreg[11:8]`, data = `shreg[7:0]`, and bits [15:12] are ignored. Frames longer than 16 bits keep only the last 16 bits, as a daisy chain requires.
  - Pulse `frame_valid`, update `last_addr`/`last_data`, then apply the address:
    - 0x0 (no-op), 0xD, 0xE: no register change.
    - 0x1–0x8: write `digit[addr-1]`.
    - 0x9 / 0xA / 0xB / 0xC / 0xF: write the corresponding output register.
- SCK edges seen while not in SHIFT are ignored.
- An SCK rising edge detected in the same cycle as a CS rising edge is discarded and not counted.
- `max_dout` = `shreg[15]`. It is not cleared at CS falling edges; only `reset` clears it.
- `rd_data` <= `digit[rd_addr]` every cycle.

## Timing
- Reset values: all eight digits = 0x00, `decode_mode` = 0, `intensity` = 0, `scan_limit` = 0, `shutdown` = 1, `display_test` = 0. `frame_valid`, `frame_error`, `max_dout`, `rd_data`, `last_addr`, `last_data` all = 0. State = WAIT_HIGH.
- A pin transition is seen as an edge `SYNC_STAGES`+1 cycles later.
- Registers update and `frame_valid`/`frame_error` pulse exactly `SYNC_STAGES`+2 cycles after the CS pin rises.
- Register outputs are stable from that cycle onward.
- Input requirements:
  - SCK high and low phases each ≥ `SYNC_STAGES`+1 clock cycles.
  - CS high time between frames ≥ `SYNC_STAGES`+2 cycles.
  - DIN must be stable for 1 cycle before and after each SCK pin rising edge.
- `rd_data` latency: 1 cycle after `rd_addr` changes.
- `reset` has priority over every event in the same cycle.

## Structure
- Package `max7219_pkg`:
  - Register address constants: `ADDR_NOOP`, `ADDR_DIGIT0`..`ADDR_DIGIT7`, `ADDR_DECODE`, `ADDR_INTENSITY`, `ADDR_SCANLIM`, `ADDR_SHUTDOWN`, `ADDR_TEST`.
  - The state enum and `FRAME_BITS` = 16.
- Sub-module `sync_edge`: parameterized synchronizer with rise/fall outputs. Instantiated for SCK and CS; DIN uses its synchronized output only.

## Test plan
- After reset, frame 0x0A05 -> one `frame_valid` pulse, `intensity` = 5, `last_addr` = 0xA, `last_data` = 0x05, `shutdown` still 1.
- Frame 0x0137, then `rd_addr` = 0 -> `rd_data` = 0x37 one cycle later. Frame 0x0C01 -> `shutdown` = 0.
- 12-bit frame 0xA05 -> one `frame_error` pulse, no `frame_valid`, all registers and `last_*` unchanged.
- 32-bit frame 0x0C01_0F01 -> only 0x0F01 is applied: `display_test` = 1, `shutdown` = 1. `max_dout` carries 0x0C01 MSB-first during the second 16 bits.
- `reset` pulsed after 8 bits of 0x0B07 with CS held low, followed by 8 more bits and CS high -> no pulses and reset values kept. Next full frame 0x0B07 -> `scan_limit` = 7.
- 20 SCK pulses with CS high, then frame 0x0900 -> no effect from the pulses; `decode_mode` = 0x00 with a single `frame_valid`.
